// File: rtl/branch_prediction_unit.sv
// branch_prediction_unit: 2-bit saturating-counter BHT with combinational JAL/branch target prediction
module branch_prediction_unit #(
  parameter int ADDRESS_SIZE     = 64,
  parameter int INSTRUCTION_SIZE = 32,
  parameter int BHT_ENTRIES      = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ADDRESS_SIZE-1:0]     pc,
  input  logic [INSTRUCTION_SIZE-1:0] instruction,
  input  logic                        update_valid,
  input  logic [ADDRESS_SIZE-1:0]     update_pc,
  input  logic                        update_taken,
  output logic [ADDRESS_SIZE-1:0]     next_pc,
  output logic                        overwrite_pc
);
  localparam int IW = $clog2(BHT_ENTRIES);
  logic [1:0] bht_q [BHT_ENTRIES];
  logic [1:0] cnt_d;
  logic [IW-1:0] p_idx, u_idx;
  logic [20:0] j_imm;
  logic [12:0] b_imm;
  logic is_jal, is_br, take;
  logic unused_ok;
  assign p_idx = pc[IW+1:2];
  assign u_idx = update_pc[IW+1:2];
  assign unused_ok = ^{update_pc[ADDRESS_SIZE-1:IW+2], update_pc[1:0]};
  assign j_imm = {instruction[31], instruction[19:12], instruction[20], instruction[30:21], 1'b0};
  assign b_imm = {instruction[31], instruction[7], instruction[30:25], instruction[11:8], 1'b0};
  assign is_jal = instruction[6:0] == 7'b1101111;
  assign is_br = instruction[6:0] == 7'b1100011;
  assign take = is_br & bht_q[p_idx][1];
  always_comb begin
    next_pc = is_jal ? pc + {{(ADDRESS_SIZE-21){j_imm[20]}}, j_imm}
            : take   ? pc + {{(ADDRESS_SIZE-13){b_imm[12]}}, b_imm}
            :          pc + ADDRESS_SIZE'(4);
    overwrite_pc = is_jal | take;
    cnt_d = update_taken ? (bht_q[u_idx] == 2'b11 ? 2'b11 : bht_q[u_idx] + 2'd1)
          :                (bht_q[u_idx] == 2'b00 ? 2'b00 : bht_q[u_idx] - 2'd1);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset)
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    else if (update_valid)
      bht_q[u_idx] <= cnt_d;
endmodule

// File: tb/tb_branch_prediction_unit.sv
// tb_branch_prediction_unit: directed self-checking bench for branch_prediction_unit
module tb_branch_prediction_unit;
  localparam logic [31:0] JAL  = 32'h0080006F;
  localparam logic [31:0] BEQ  = 32'hFE000CE3;
  localparam logic [31:0] JALR = 32'h00008067;
  logic clk = 0, reset = 1;
  logic [63:0] pc = 0, update_pc = 0, next_pc;
  logic [31:0] instruction = 0;
  logic update_valid = 0, update_taken = 0, overwrite_pc;
  int tests = 0, fails = 0;

  branch_prediction_unit dut (
    .clk(clk), .reset(reset), .pc(pc), .instruction(instruction),
    .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
    .next_pc(next_pc), .overwrite_pc(overwrite_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pred(input string tag, input logic [63:0] p, input logic [31:0] ins,
                      input logic [63:0] exp_pc, input logic exp_ov);
    pc = p;
    instruction = ins;
    #1;
    check({tag, ".next_pc"}, next_pc, exp_pc);
    check({tag, ".overwrite"}, {63'd0, overwrite_pc}, {63'd0, exp_ov});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [63:0] a, input logic t, input int n);
    update_pc = a;
    update_taken = t;
    update_valid = 1;
    repeat (n) tick();
    update_valid = 0;
  endtask

  initial begin
    pred("rst_beq", 64'h2000, BEQ, 64'h2004, 0);
    upd(64'h2000, 1, 3);
    pred("rst_upd_ignored", 64'h2000, BEQ, 64'h2004, 0);
    reset = 0;
    pred("jal", 64'h1000, JAL, 64'h1008, 1);
    pred("beq_init", 64'h2000, BEQ, 64'h2004, 0);
    upd(64'h2000, 1, 1);
    pred("beq_wt", 64'h2000, BEQ, 64'h1FF8, 1);
    upd(64'h2000, 1, 3);
    upd(64'h2000, 0, 1);
    pred("beq_sat_nt1", 64'h2000, BEQ, 64'h1FF8, 1);
    upd(64'h2000, 0, 1);
    pred("beq_sat_nt2", 64'h2000, BEQ, 64'h2004, 0);
    update_taken = 1;
    repeat (3) tick();
    pred("hold", 64'h2000, BEQ, 64'h2004, 0);
    update_pc = 64'h2000;
    update_valid = 1;
    pred("no_bypass", 64'h2000, BEQ, 64'h2004, 0);
    tick();
    update_valid = 0;
    pred("after_bypass_edge", 64'h2000, BEQ, 64'h1FF8, 1);
    pred("jalr", 64'h3000, JALR, 64'h3004, 0);
    pred("zero_ins", 64'h3000, 32'h0, 64'h3004, 0);
    pred("other_idx", 64'h2004, BEQ, 64'h2008, 0);
    upd(64'h2000, 1, 1);
    pred("wrap", 64'h0, BEQ, 64'hFFFF_FFFF_FFFF_FFF8, 1);
    pred("jal_wrap", 64'hFFFF_FFFF_FFFF_FFFC, JAL, 64'h4, 1);
    reset = 1;
    #1;
    reset = 0;
    upd(64'h2000, 1, 2);
    pred("alias", 64'h2100, BEQ, 64'h20F8, 1);
    #1;
    reset = 1;
    pred("async_rst", 64'h2100, BEQ, 64'h2104, 0);
    tick();
    reset = 0;
    upd(64'h2000, 0, 2);
    upd(64'h2000, 1, 1);
    pred("sat_low", 64'h2000, BEQ, 64'h2004, 0);
    upd(64'h2000, 1, 1);
    pred("from_low", 64'h2000, BEQ, 64'h1FF8, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/branch_prediction_unit.md
BRANCH_PREDICTION_UNIT -- requirements
Module: branch_prediction_unit

Interface
REQ-001 The module SHALL have parameter ADDRESS_SIZE, default 64, meaning the PC and target width in bits.
REQ-002 The module SHALL have parameter INSTRUCTION_SIZE, default 32, meaning the instruction word width (RV64I encoding).
REQ-003 The module SHALL have parameter BHT_ENTRIES, default 64, meaning the number of 2-bit counters, a power of two.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The module SHALL have port pc, input, ADDRESS_SIZE bits: address of the instruction being predicted.
REQ-007 The module SHALL have port instruction, input, INSTRUCTION_SIZE bits: fetched instruction word at pc.
REQ-008 The module SHALL have port update_valid, input, 1 bit: a resolved conditional branch is reported this cycle.
REQ-009 The module SHALL have port update_pc, input, ADDRESS_SIZE bits: PC of the resolved branch.
REQ-010 The module SHALL have port update_taken, input, 1 bit: actual outcome of the resolved branch.
REQ-011 The module SHALL have port next_pc, output, ADDRESS_SIZE bits: predicted fetch address following pc.
REQ-012 The module SHALL have port overwrite_pc, output, 1 bit: 1 when next_pc differs from sequential pc+4 and fetch must redirect.

Function
REQ-013 The prediction path (next_pc, overwrite_pc) SHALL be purely combinational from pc, instruction and current BHT state, with zero-cycle latency.
REQ-014 The BHT index SHALL be pc[log2(BHT_ENTRIES)+1:2] for prediction and update_pc bits [log2(BHT_ENTRIES)+1:2] for update, with no tag check, so aliasing is permitted.
REQ-015 For opcode 1101111 (JAL), the unit SHALL set next_pc = pc + sign-extended J-immediate and overwrite_pc = 1, regardless of the BHT.
REQ-016 For opcode 1100011 (conditional branch), the unit SHALL predict taken when the indexed counter MSB = 1.
- Taken: next_pc = pc + sign-extended B-immediate, overwrite_pc = 1.
- Not taken: next_pc = pc + 4, overwrite_pc = 0.
REQ-017 For opcode 1100111 (JALR), all other opcodes, and instruction = 0, the unit SHALL output next_pc = pc + 4 and overwrite_pc = 0.
REQ-018 All target additions SHALL be modulo 2^ADDRESS_SIZE, with immediates sign-extended to ADDRESS_SIZE; wrap-around is not flagged.
REQ-019 On a rising clk with update_valid = 1, the indexed counter SHALL increment when update_taken = 1, saturating at 2'b11.
REQ-020 On a rising clk with update_valid = 1, the indexed counter SHALL decrement when update_taken = 0, saturating at 2'b00.
REQ-021 When update_valid = 0, all counters SHALL hold their values.
REQ-022 When update and prediction target the same index in the same cycle, the prediction SHALL use the pre-update counter value, with no bypass.
REQ-023 The update path SHALL ignore the instruction input; updates are accepted for any update_pc.

Reset
REQ-024 While reset = 1, asynchronously and independent of clk, all BHT counters SHALL be 2'b01 (weakly not-taken).
REQ-025 During reset, the outputs SHALL follow REQ-013..REQ-017 using the reset counter values, so a conditional branch predicts not-taken.
REQ-026 Assertion of reset mid-operation SHALL discard all training, and updates presented while reset = 1 SHALL be ignored.
REQ-027 After reset deasserts, the first rising clk SHALL accept an update normally.

Verification
REQ-028 After reset, pc = 0x1000, instruction = 0x0080006F (jal x0,+8) -> next_pc = 0x1008, overwrite_pc = 1.
REQ-029 After reset, pc = 0x2000, instruction = 0xFE000CE3 (beq x0,x0,-8) -> next_pc = 0x2004, overwrite_pc = 0.
REQ-030 Continuing REQ-029, one update (update_pc = 0x2000, taken = 1) -> counter 2'b10, same input predicts next_pc = 0x1FF8, overwrite_pc = 1.
REQ-031 Continuing REQ-030:
- Three more taken updates -> counter saturates at 2'b11.
- Then one not-taken update -> still predicts taken.
- A second not-taken update -> predicts not-taken, next_pc = 0x2004.
REQ-032 pc = 0x3000, instruction = 0x00008067 (jalr x0,0(x1)), or instruction = 0x00000000 -> next_pc = 0x3004, overwrite_pc = 0.
REQ-033 Aliasing and reset check:
- Train pc 0x2000 taken twice with BHT_ENTRIES = 64.
- Then a branch at 0x2100 (same index) predicts taken.
- Asserting reset between clock edges immediately returns predictions to not-taken.
